// File: rtl/dma_controller.sv
// Line-oriented DMA engine: on a device interrupt it asks the CPU for a
// command, then steals the bus (br/bg) to copy up to DATA_SIZE device lines
// into memory, one line-write per chunk, and signals completion.
module dma_controller #(
   parameter int WORD_SIZE      = 16,
   parameter int LINE_WORDS     = 4,
   parameter int DATA_SIZE      = 3,
   parameter int DEVICE_BIT_LEN = 2
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             ext_interrupt,
   output logic [DEVICE_BIT_LEN-1:0]        offset,
   input  logic [LINE_WORDS*WORD_SIZE-1:0]  ext_data,
   output logic                             dma_begin_int,
   input  logic                             cmd_valid,
   input  logic [WORD_SIZE-1:0]             cmd_addr,
   input  logic [WORD_SIZE-1:0]             cmd_length,
   output logic                             br,
   input  logic                             bg,
   output logic                             mem_write,
   output logic [WORD_SIZE-1:0]             mem_addr,
   output logic [LINE_WORDS*WORD_SIZE-1:0]  mem_data,
   input  logic                             mem_ready,
   output logic                             dma_end_int
);

   localparam int CW = $clog2(DATA_SIZE + 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_CMD,
      REQ,
      SETUP,
      WRITE,
      DONE
   } state_t;

   state_t               state, state_nx;
   logic                 int_q;
   logic                 int_rise;
   logic [CW-1:0]        k;
   logic [CW-1:0]        k_inc;
   logic [CW-1:0]        num_chunks;
   logic [CW-1:0]        cmd_chunks;
   logic [WORD_SIZE-1:0] base;
   logic [WORD_SIZE:0]   chunks_raw;

   assign int_rise = ext_interrupt & ~int_q;
   assign k_inc    = k + CW'(1);

   // Chunk count of the incoming command: ceil(length/LINE_WORDS), capped at DATA_SIZE
   always_comb begin
      chunks_raw = ({1'b0, cmd_length} + (WORD_SIZE+1)'(LINE_WORDS - 1))
                   / (WORD_SIZE+1)'(LINE_WORDS);
      if (chunks_raw > (WORD_SIZE+1)'(DATA_SIZE))
         cmd_chunks = CW'(DATA_SIZE);
      else
         cmd_chunks = CW'(chunks_raw);
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Interrupt edge register, begin pulse, command latch and chunk counter
   always_ff @(posedge clk) begin
      if (reset) begin
         int_q         <= 1'b0;
         dma_begin_int <= 1'b0;
         k             <= '0;
         num_chunks    <= '0;
         base          <= '0;
      end else begin
         int_q         <= ext_interrupt;
         dma_begin_int <= (state == IDLE) && int_rise;
         if (state == WAIT_CMD && cmd_valid) begin
            num_chunks <= cmd_chunks;
            base       <= cmd_addr;
            k          <= '0;
         end else if (state == WRITE && mem_ready) begin
            k <= k_inc;
         end
      end
   end

   // Next-state and bus-side outputs
   always_comb begin
      state_nx    = state;
      br          = 1'b0;
      offset      = '1;
      mem_write   = 1'b0;
      mem_addr    = '0;
      mem_data    = '0;
      dma_end_int = 1'b0;
      case (state)
         IDLE: begin
            if (int_rise)
               state_nx = WAIT_CMD;
         end
         WAIT_CMD: begin
            if (cmd_valid)
               state_nx = (cmd_chunks == '0) ? DONE : REQ;
         end
         REQ: begin
            br = 1'b1;
            if (bg)
               state_nx = SETUP;
         end
         SETUP: begin
            br     = 1'b1;
            offset = DEVICE_BIT_LEN'(k);
            state_nx = bg ? WRITE : REQ;
         end
         WRITE: begin
            // grant withdrawal is deliberately ignored here: a started write finishes
            br        = 1'b1;
            offset    = DEVICE_BIT_LEN'(k);
            mem_write = 1'b1;
            mem_data  = ext_data;
            mem_addr  = base + WORD_SIZE'(LINE_WORDS) * WORD_SIZE'(k);
            if (mem_ready)
               state_nx = (k_inc == num_chunks) ? DONE : SETUP;
         end
         DONE: begin
            dma_end_int = 1'b1;
            state_nx    = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dma_controller.sv
// Self-checking bench for dma_controller: device and memory/bus models,
// a cycle monitor with protocol invariants, and a transfer-level reference
// model (expected address/data list) compared against accepted writes.
module tb_dma_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        ext_interrupt;
   logic [1:0]  offset;
   logic [63:0] ext_data;
   logic        dma_begin_int;
   logic        cmd_valid;
   logic [15:0] cmd_addr;
   logic [15:0] cmd_length;
   logic        br;
   logic        bg;
   logic        mem_write;
   logic [15:0] mem_addr;
   logic [63:0] mem_data;
   logic        mem_ready;
   logic        dma_end_int;

   dma_controller #(
      .WORD_SIZE(16),
      .LINE_WORDS(4),
      .DATA_SIZE(3),
      .DEVICE_BIT_LEN(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .ext_interrupt(ext_interrupt),
      .offset(offset),
      .ext_data(ext_data),
      .dma_begin_int(dma_begin_int),
      .cmd_valid(cmd_valid),
      .cmd_addr(cmd_addr),
      .cmd_length(cmd_length),
      .br(br),
      .bg(bg),
      .mem_write(mem_write),
      .mem_addr(mem_addr),
      .mem_data(mem_data),
      .mem_ready(mem_ready),
      .dma_end_int(dma_end_int)
   );

   always #5 clk = ~clk;

   // device model: four stored lines selected by offset
   logic [63:0] lines [4];
   assign ext_data = lines[offset];

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [15:0] addr;
      logic [63:0] data;
      int          c;
   } wr_t;
   wr_t acc_q[$];

   int cyc = 0;
   int begin_cnt = 0, end_cnt = 0;
   int begin_cyc = 0, end_cyc = 0, cmd_cyc = 0, int_cyc = 0;

   // bus/memory model controls
   bit bg_always  = 1'b0;
   bit rdy_random = 1'b0;
   bit stall_arm  = 1'b0;
   bit drop_arm   = 1'b0;
   bit drop_now   = 1'b0;
   bit br_prev    = 1'b0;
   int stall_left = 0;
   int drop_left  = 0;

   // grant/ready driver: bg follows br one cycle late unless forced
   initial begin
      bg        = 1'b0;
      mem_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (drop_arm && br && !mem_write && offset == 2'd2) begin
            drop_arm  = 1'b0;
            drop_left = 3;
         end
         if (stall_arm && mem_write && offset == 2'd1) begin
            stall_arm  = 1'b0;
            stall_left = 4;
         end
         if (drop_left > 0) begin
            bg       = 1'b0;
            drop_now = 1'b1;
            drop_left--;
         end else begin
            drop_now = 1'b0;
            bg       = bg_always ? 1'b1 : br_prev;
         end
         if (stall_left > 0) begin
            mem_ready = 1'b0;
            stall_left--;
         end else begin
            mem_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         br_prev = br;
      end
   end

   // cycle monitor
   bit          prev_mw = 0, prev_rdy = 0, prev_rst = 1, prev_bg = 0, prev_ext = 0, br_seen = 0;
   logic [15:0] prev_addr = '0;
   logic [63:0] prev_data = '0;

   initial begin
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (!reset) begin
            if (ext_interrupt && !prev_ext) int_cyc = cyc;
            if (cmd_valid) cmd_cyc = cyc;
            if (dma_begin_int) begin begin_cnt++; begin_cyc = cyc; end
            if (dma_end_int) begin end_cnt++; end_cyc = cyc; end
            if (br) br_seen = 1'b1;
            if (!br) check("offset_idle", 64'(offset), 64'd3);
            if (mem_write) begin
               check("mw_needs_br", 64'(br), 64'd1);
               check("mw_data_line", mem_data, lines[offset]);
               if (!prev_mw) check("mw_after_grant", 64'(prev_bg), 64'd1);
            end
            if (prev_mw && !prev_rdy && !prev_rst) begin
               check("hold_mw", 64'(mem_write), 64'd1);
               check("hold_addr", 64'(mem_addr), 64'(prev_addr));
               check("hold_data", mem_data, prev_data);
            end
            if (drop_now) begin
               check("drop_br", 64'(br), 64'd1);
               check("drop_no_write", 64'(mem_write), 64'd0);
            end
            if (mem_write && mem_ready) acc_q.push_back('{mem_addr, mem_data, cyc});
         end
         prev_mw   = mem_write;
         prev_rdy  = mem_ready;
         prev_rst  = reset;
         prev_bg   = bg;
         prev_ext  = ext_interrupt;
         prev_addr = mem_addr;
         prev_data = mem_data;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic new_lines();
      for (int i = 0; i < 4; i++) lines[i] = {$urandom, $urandom};
   endtask

   // interrupt held hi cycles; exactly one begin pulse one cycle after the rise
   task automatic start_xfer(input int hi);
      int b0;
      b0 = begin_cnt;
      @(negedge clk);
      ext_interrupt = 1'b1;
      tick(hi);
      ext_interrupt = 1'b0;
      check("begin_count", 64'(begin_cnt - b0), 64'd1);
      check("begin_latency", 64'(begin_cyc - int_cyc), 64'd1);
   endtask

   task automatic send_cmd(input logic [15:0] a, input logic [15:0] len);
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_addr   = a;
      cmd_length = len;
      @(negedge clk);
      cmd_valid  = 1'b0;
      cmd_addr   = 16'($urandom);
      cmd_length = 16'($urandom);
   endtask

   task automatic wait_end(input int e0);
      for (int i = 0; i < 300 && end_cnt == e0; i++) @(negedge clk);
      tick(3);
      check("end_count", 64'(end_cnt - e0), 64'd1);
      check("br_after_end", 64'(br), 64'd0);
   endtask

   // reference model: list of (address, line) writes implied by the command
   task automatic expect_writes(input logic [15:0] a, input logic [15:0] len);
      int nch;
      logic [15:0] ea;
      nch = (int'(len) + 3) / 4;
      if (nch > 3) nch = 3;
      check("write_count", 64'(acc_q.size()), 64'(nch));
      for (int k = 0; k < nch && k < acc_q.size(); k++) begin
         ea = 16'((int'(a) + 4 * k) % 65536);
         check("write_addr", 64'(acc_q[k].addr), 64'(ea));
         check("write_data", acc_q[k].data, lines[k]);
      end
      if (nch > 0 && acc_q.size() > 0)
         check("end_after_last_write", 64'(end_cyc - acc_q[acc_q.size()-1].c), 64'd1);
      else if (nch == 0)
         check("end_after_cmd", 64'(end_cyc - cmd_cyc), 64'd1);
   endtask

   task automatic run_xfer(input logic [15:0] a, input logic [15:0] len, input int hi);
      int e0;
      new_lines();
      acc_q.delete();
      br_seen = 1'b0;
      start_xfer(hi);
      e0 = end_cnt;
      send_cmd(a, len);
      wait_end(e0);
      expect_writes(a, len);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int b0, e0;
      reset = 1'b1; ext_interrupt = 1'b0; cmd_valid = 1'b0;
      cmd_addr = '0; cmd_length = '0;
      new_lines();
      tick(2);
      check("rst_br", 64'(br), 64'd0);
      check("rst_mem_write", 64'(mem_write), 64'd0);
      check("rst_offset", 64'(offset), 64'd3);
      check("rst_begin", 64'(dma_begin_int), 64'd0);
      check("rst_end", 64'(dma_end_int), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      reset = 1'b0;
      tick(2);

      // basic 12-word transfer
      run_xfer(16'h0040, 16'd12, 10);
      // partial length, saturation, zero length
      run_xfer(16'h0040, 16'd5, 3);
      run_xfer(16'h0040, 16'd100, 3);
      run_xfer(16'h0040, 16'd0, 3);
      check("len0_no_br", 64'(br_seen), 64'd0);
      // back-pressure on chunk 1
      stall_arm = 1'b1;
      run_xfer(16'h0040, 16'd12, 3);
      // grant withdrawn in SETUP of chunk 2
      drop_arm = 1'b1;
      run_xfer(16'h0040, 16'd12, 3);
      check("drop_reached", 64'(drop_arm), 64'd0);
      // address wrap
      run_xfer(16'hFFFC, 16'd8, 3);

      // latency with grant already present and memory always ready
      bg_always = 1'b1;
      run_xfer(16'h0100, 16'd12, 3);
      if (acc_q.size() == 3) begin
         check("lat_first_write", 64'(acc_q[0].c - cmd_cyc), 64'd3);
         check("lat_chunk1", 64'(acc_q[1].c - acc_q[0].c), 64'd2);
         check("lat_chunk2", 64'(acc_q[2].c - acc_q[1].c), 64'd2);
      end
      bg_always = 1'b0;

      // second interrupt during WRITE, then reset mid-WRITE
      new_lines();
      acc_q.delete();
      start_xfer(2);
      stall_arm = 1'b1;
      e0 = end_cnt;
      send_cmd(16'h0040, 16'd12);
      for (int i = 0; i < 50 && !(mem_write && offset == 2'd1); i++) @(negedge clk);
      check("t5_in_write1", 64'(mem_write && offset == 2'd1), 64'd1);
      b0 = begin_cnt;
      ext_interrupt = 1'b1;
      tick(2);
      ext_interrupt = 1'b0;
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("t5_no_begin", 64'(begin_cnt - b0), 64'd0);
      check("t5_rst_br", 64'(br), 64'd0);
      check("t5_rst_mw", 64'(mem_write), 64'd0);
      check("t5_rst_offset", 64'(offset), 64'd3);
      tick(10);
      check("t5_no_end", 64'(end_cnt - e0), 64'd0);
      check("t5_one_write", 64'(acc_q.size()), 64'd1);
      run_xfer(16'h0200, 16'd12, 3);

      // randomized transfers
      rdy_random = 1'b1;
      for (int n = 0; n < 10; n++) begin
         bg_always = 1'($urandom_range(0, 1));
         run_xfer(16'($urandom), 16'($urandom_range(0, 20)), $urandom_range(2, 6));
      end
      rdy_random = 1'b0;
      bg_always  = 1'b0;
      tick(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
